// File: rtl/alu_pipe_pkg.sv
// Shared opcode map and flag bundle for alu_pipe.
package alu_pipe_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ROR   = 4'd0;
  localparam opcode_t OP_ADD   = 4'd1;
  localparam opcode_t OP_XOR   = 4'd2;
  localparam opcode_t OP_NAND  = 4'd3;
  localparam opcode_t OP_SUB   = 4'd4;
  localparam opcode_t OP_SGT   = 4'd5;
  localparam opcode_t OP_SEQ   = 4'd6;
  localparam opcode_t OP_XNOR  = 4'd7;
  localparam opcode_t OP_MAX   = 4'd8;
  localparam opcode_t OP_PASSB = 4'd9;
  localparam opcode_t OP_LAST  = 4'd9;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: opcode + operands + rotate amount -> result and flags.
// Define ALU_PIPE_SATURATE_EN to make ADD/SUB saturate on signed overflow.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  opcode_t            opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHW-1:0]     shiftValue,
  output logic [WIDTH-1:0]   result,
  output flags_t             flags
);

  logic [2*WIDTH-1:0] rot;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res;
  logic               c;
  logic               o;
  logic               il;

  always_comb begin
    sum  = {1'b0, input1} + {1'b0, input2};
    diff = {1'b0, input1} - {1'b0, input2};
    rot  = {input1, input1} >> (int'(shiftValue) % WIDTH);
    res  = '0;
    c    = 1'b0;
    o    = 1'b0;
    il   = 1'b0;
    case (opcode)
      OP_ROR:   res = rot[WIDTH-1:0];
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        o   = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_XOR:   res = input1 ^ input2;
      OP_NAND:  res = ~(input1 & input2);
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        o   = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SGT:   res = {{(WIDTH-1){1'b0}}, ($signed(input1) > $signed(input2))};
      OP_SEQ:   res = {{(WIDTH-1){1'b0}}, (input1 == input2)};
      OP_XNOR:  res = ~(input1 ^ input2);
      OP_MAX:   res = (input1 >= input2) ? input1 : input2;
      OP_PASSB: res = input2;
      default:  il  = 1'b1;
    endcase
`ifdef ALU_PIPE_SATURATE_EN
    // For both ADD and SUB an overflow is positive exactly when input1 is non-negative.
    if ((opcode == OP_ADD || opcode == OP_SUB) && o)
      res = input1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    result         = res;
    flags.carry    = c;
    flags.zero     = (res == '0);
    flags.overflow = o;
    flags.illegal  = il;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU; owns the handshake and all registers.
// Optional build macro: ALU_PIPE_SATURATE_EN (saturating ADD/SUB in alu_pipe_core).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             illegalFlag
);

  logic             en;
  logic             s1_valid;
  opcode_t          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [SHW-1:0]   s1_sh;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  flags_t           out_flags;

  // Whole pipe moves as one; bubbles in stage 1 are not squeezed out.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .opcode     (s1_op),
    .input1     (s1_a),
    .input2     (s1_b),
    .shiftValue (s1_sh),
    .result     (core_res),
    .flags      (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sh     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_flags <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_op     <= opcode;
      s1_a      <= input1;
      s1_b      <= input2;
      s1_sh     <= shiftValue;
      out_valid <= s1_valid;
      result    <= core_res;
      out_flags <= core_flags;
    end
  end

  assign carryFlag    = out_flags.carry;
  assign zeroFlag     = out_flags.zero;
  assign overFlowFlag = out_flags.overflow;
  assign illegalFlag  = out_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: directed test-plan cases, backpressure, random, reset.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] input1;
  logic [7:0] input2;
  logic [2:0] shiftValue;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carryFlag;
  logic       zeroFlag;
  logic       overFlowFlag;
  logic       illegalFlag;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;   // {carry, zero, overflow, illegal}
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_pushed  = 0;
  int   n_out     = 0;
  int   n_flushed = 0;
  logic stall_prev = 1'b0;
  logic [11:0] held;
  logic rnd_done;

  alu_pipe #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .input1       (input1),
    .input2       (input2),
    .shiftValue   (shiftValue),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carryFlag    (carryFlag),
    .zeroFlag     (zeroFlag),
    .overFlowFlag (overFlowFlag),
    .illegalFlag  (illegalFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.fl  = f;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] sh);
    int ua, ub, sa, sb2, r, s;
    logic c, o, il;
    ua = int'(a); ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb2 = b[7] ? ub - 256 : ub;
    r = 0; c = 0; o = 0; il = 0; s = 0;
    case (op)
      4'd0: r = ((ua >> sh) | (ua << (8 - int'(sh)))) & 255;
      4'd1: begin
        s = sa + sb2; r = (ua + ub) & 255; c = (ua + ub) > 255; o = (s > 127) || (s < -128);
      end
      4'd2: r = ua ^ ub;
      4'd3: r = ~(ua & ub) & 255;
      4'd4: begin
        s = sa - sb2; r = (ua - ub) & 255; c = ua < ub; o = (s > 127) || (s < -128);
      end
      4'd5: r = (sa > sb2) ? 1 : 0;
      4'd6: r = (ua == ub) ? 1 : 0;
      4'd7: r = ~(ua ^ ub) & 255;
      4'd8: r = (ua >= ub) ? ua : ub;
      4'd9: r = ub;
      default: il = 1;
    endcase
`ifdef ALU_PIPE_SATURATE_EN
    if (o) r = (s > 127) ? 127 : 128;
`endif
    return mk(8'(r), {c, (r == 0), o, il});
  endfunction

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sh, input exp_t e);
    int t;
    in_valid = 1'b1; opcode = op; input1 = a; input2 = b; shiftValue = sh;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
    else begin
      sb.push_back(e);
      n_pushed++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid)
        check("stall_hold", 32'({result, carryFlag, zeroFlag, overFlowFlag, illegalFlag}), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 32'(1), 32'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          n_out++;
          check("result", 32'(result), 32'(e.res));
          check("flags", 32'({carryFlag, zeroFlag, overFlowFlag, illegalFlag}), 32'(e.fl));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {result, carryFlag, zeroFlag, overFlowFlag, illegalFlag};
    end
  end

  initial begin
    exp_t add_ovf;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; input1 = '0; input2 = '0; shiftValue = '0; rnd_done = 1'b0;

    @(posedge clk); @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'({carryFlag, zeroFlag, overFlowFlag, illegalFlag}), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef ALU_PIPE_SATURATE_EN
    add_ovf = mk(8'h7F, 4'b0010);
`else
    add_ovf = mk(8'h80, 4'b0010);
`endif
    drive(4'd1, 8'h7F, 8'h01, 3'd0, add_ovf);
    check("lat_stage1", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("lat_stage2", 32'(out_valid), 32'(1));

    drive(4'd4, 8'h00, 8'h01, 3'd0, mk(8'hFF, 4'b1000));
    drive(4'd4, 8'h05, 8'h05, 3'd0, mk(8'h00, 4'b0100));
    drive(4'd0, 8'h81, 8'h00, 3'd1, mk(8'hC0, 4'b0000));
    drive(4'd5, 8'h80, 8'h01, 3'd0, mk(8'h00, 4'b0100));
    drive(4'd6, 8'h3C, 8'h3C, 3'd0, mk(8'h01, 4'b0000));
    drive(4'd8, 8'h80, 8'h7F, 3'd0, mk(8'h80, 4'b0000));
    drive(4'hC, 8'h12, 8'h34, 3'd5, mk(8'h00, 4'b0101));
    drive(4'd2, 8'hF0, 8'hFF, 3'd0, mk(8'h0F, 4'b0000));
    drive(4'd3, 8'hFF, 8'hFF, 3'd0, mk(8'h00, 4'b0100));
    drive(4'd7, 8'hA5, 8'h5A, 3'd0, mk(8'h00, 4'b0100));
    drive(4'd9, 8'h12, 8'h34, 3'd0, mk(8'h34, 4'b0000));
    drive(4'd0, 8'h81, 8'h00, 3'd0, mk(8'h81, 4'b0000));
    drain();

    // Backpressure: four back-to-back ADDs, consumer stalls 3 cycles once output appears.
    fork
      begin
        drive(4'd1, 8'h01, 8'h02, 3'd0, model(4'd1, 8'h01, 8'h02, 3'd0));
        drive(4'd1, 8'h10, 8'h20, 3'd0, model(4'd1, 8'h10, 8'h20, 3'd0));
        drive(4'd1, 8'hFF, 8'h01, 3'd0, model(4'd1, 8'hFF, 8'h01, 3'd0));
        drive(4'd1, 8'h80, 8'h80, 3'd0, model(4'd1, 8'h80, 8'h80, 3'd0));
      end
      begin
        logic [7:0] cap;
        for (int t = 0; t < 20 && !out_valid; t++) begin
          @(posedge clk); #1;
        end
        if (!out_valid) check("bp_valid_timeout", 32'(out_valid), 32'(1));
        out_ready = 1'b0;
        cap = result;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'(0));
          check("bp_hold", 32'(result), 32'(cap));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [3:0] op;
          logic [7:0] a, b;
          logic [2:0] sh;
          op = 4'($urandom_range(0, 15));
          a  = 8'($urandom);
          b  = 8'($urandom);
          sh = 3'($urandom_range(0, 7));
          drive(op, a, b, sh, model(op, a, b, sh));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two bundles in flight: both must vanish.
    drive(4'd2, 8'h11, 8'h22, 3'd0, mk(8'h33, 4'b0000));
    drive(4'd9, 8'h00, 8'h55, 3'd0, mk(8'h55, 4'b0000));
    rst = 1'b1;
    out_ready = 1'b0;
    n_flushed += sb.size();
    sb.delete();
    @(posedge clk); @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'(0));
    check("mrst_result", 32'(result), 32'(0));
    check("mrst_flags", 32'({carryFlag, zeroFlag, overFlowFlag, illegalFlag}), 32'(0));
    check("mrst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'd1, 8'h40, 8'h02, 3'd0, mk(8'h42, 4'b0000));
    check("post_rst_lat1", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("post_rst_lat2", 32'(out_valid), 32'(1));
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("out_count", 32'(n_out), 32'(n_pushed - n_flushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the generated 8-bit ALUs.
- Same opcode map (ROR, ADD, XOR, NAND, SUB, SGT, SEQ, XNOR, MAX, PASSB), generalised to WIDTH bits.
- Operands and results move through a valid/ready handshake; result and flags are registered.
- Sits between an operand-issue unit and a writeback/flag consumer that can apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2).
- SHW, $clog2(WIDTH), width of shiftValue.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- opcode  input  4  operation select.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- shiftValue  input  SHW  rotate amount for ROR.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- carryFlag  output  1  carry-out (ADD) / borrow (SUB).
- zeroFlag  output  1  result == 0.
- overFlowFlag  output  1  signed overflow (ADD/SUB).
- illegalFlag  output  1  opcode 10–15 was issued.

Behaviour:
- Reset: the clock and reset are fixed. One clock, clk. Reset rst is synchronous and active-high. While rst is sampled high: out_valid=0, result=0, all flags=0, stage-1 valid=0. in_ready is 0 during the reset cycle.
- Reset mid-operation: any in-flight bundles are discarded with no output.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational, when not in reset).
- Accept: a bundle is accepted on a cycle where in_valid && in_ready. Stage 1 captures opcode, operands and shiftValue, and s1_valid <= in_valid when en.
- Stage 2 (when en): computes from the stage-1 registers and loads result/flags. out_valid <= s1_valid.
- Stall: when en=0, both stages hold. Outputs are stable while out_valid && !out_ready.
- Latency: 2 cycles from accept to out_valid with no stalls. Throughput is 1 per cycle.
- Bubbles are not collapsed: an empty stage 1 still advances only with en.
- Opcodes:
  - 0 ROR: rotate input1 right by shiftValue mod WIDTH. A shift of 0 passes input1.
  - 1 ADD: input1+input2 mod 2^WIDTH. carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow when both operands have the same sign and the result sign differs.
  - 2 XOR.
  - 3 NAND.
  - 4 SUB: input1-input2 mod 2^WIDTH. carry = 1 when input1 < input2 unsigned (borrow). overflow when operand signs differ and the result sign differs from input1.
  - 5 SGT: result = 1 (zero-extended) if signed input1 > input2, else 0.
  - 6 SEQ: result = 1 if input1 == input2, else 0.
  - 7 XNOR.
  - 8 MAX: unsigned maximum. Ties return input1.
  - 9 PASSB: input2.
  - 10–15: result=0, illegalFlag=1.
- carryFlag and overFlowFlag are 0 for every opcode except ADD/SUB. illegalFlag is 0 for opcodes 0–9.
- zeroFlag = (result == 0) for every opcode, including illegal ones.
- All flags are registered alongside result and are valid only when out_valid=1.

Optional Feature:
- Macro: ALU_PIPE_SATURATE_EN.
- When defined, ADD and SUB saturate on signed overflow:
  - positive overflow → result 0111…1;
  - negative overflow → 1000…0.
  - overFlowFlag is still set, and carryFlag is unchanged.
  - zeroFlag is computed on the saturated value.
- When undefined, ADD and SUB wrap as specified above and there is no saturation logic.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams OP_ROR=0 … OP_PASSB=9 and OP_LAST=9;
  - a typedef for the 4-bit opcode;
  - a flags struct {carry, zero, overflow, illegal}.
- Sub-module alu_pipe_core: purely combinational WIDTH-parametrised datapath (opcode, operands, shift → result, flags). Instantiated between the stage-1 registers and the output registers.
- The top level owns the handshake and all registers.

Test Plan (WIDTH=8):
- ADD 8'h7F+8'h01, out_ready=1 → two cycles after accept: result=8'h80, overFlowFlag=1, carryFlag=0, zeroFlag=0. With ALU_PIPE_SATURATE_EN: result=8'h7F, overFlowFlag=1.
- SUB 8'h00-8'h01 → result=8'hFF, carryFlag=1, overFlowFlag=0. SUB 8'h05-8'h05 → result=0, zeroFlag=1, carryFlag=0.
- ROR 8'h81 with shiftValue=1 → 8'hC0. SGT 8'h80 vs 8'h01 → result=0. SEQ 8'h3C vs 8'h3C → result=1. MAX 8'h80 vs 8'h7F → 8'h80.
- Backpressure: stream 4 ADDs back to back, hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0, result stable, no bundle lost or duplicated; order preserved after release.
- Opcode 4'hC → result=0, zeroFlag=1, illegalFlag=1, carry/overflow=0.
- Assert rst while 2 bundles are in flight → next cycle out_valid=0, result and flags 0; first post-reset bundle emerges with 2-cycle latency.
